dsp_adc_frame_rx: RTL and testbench
===================================

// Module: dsp_adc_frame_rx
// PURPOSE
// Receive side of the radar ADC/timing interface: consumes the CPI begin/end strobes, PRI strobe,
// sample gate and the 16-bit ADC sample stream, and frames gated samples into chirps and CPI frames.
// Emits an AXI4-Stream-like output (tlast per chirp, tuser at frame start, chirp index) through a
// small FIFO to the downstream range-FFT. Flags timing/framing errors as single-cycle pulses.
// PARAMETERS
// DW          16    ADC sample width
// SMP_NUM     4096  samples per chirp (gate length in valid beats)
// CHIRP_NUM   32    chirps (PRIs) per CPI frame; CW = $clog2(CHIRP_NUM)
// FIFO_DEPTH  16    output FIFO depth (power of 2, >=4)
// PORTS
// clk           in   1   sample/processing clock
// rst_n         in   1   asynchronous active-low reset
// i_cpib        in   1   CPI begin strobe (level, rising edge significant)
// i_cpie        in   1   CPI end strobe (level, rising edge significant)
// i_pri         in   1   PRI strobe (rising edge counted, status only)
// i_smp_gate    in   1   sample gate, high while chirp samples are valid
// i_tvalid      in   1   ADC sample valid (no backpressure on input)
// i_tdata       in   DW  ADC sample
// o_tvalid      out  1   output beat valid
// i_tready      in   1   downstream ready
// o_tdata       out  DW  output sample
// o_tlast       out  1   last sample of chirp
// o_tuser       out  1   first sample of chirp 0 of frame
// o_chirp_idx   out  CW  chirp index of current beat
// o_frame_done  out  1   1-cycle pulse on accepted i_cpie rise after last chirp
// o_err_short   out  1   1-cycle pulse: gate fell with 0<count<SMP_NUM
// o_err_long    out  1   1-cycle pulse: first extra sample after SMP_NUM in a gate (once/chirp)
// o_err_sync    out  1   1-cycle pulse: cpib rise outside IDLE, or cpie rise outside WAIT_CPIE
// o_err_ovf     out  1   1-cycle pulse: FIFO write attempted while full (beat dropped)
// o_pri_cnt     out  16  PRI rising edges since last cpib rise (wraps at 2^16)
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, counters 0, FIFO empty, staging empty, edge-detect regs 0.
// - Edge detect: rise(x) = x & ~x_d1 for cpib, cpie, pri; fall(gate) = ~gate & gate_d1.
// - FSM: IDLE -rise(cpib)-> WAIT_GATE -gate high-> CAPTURE -end-of-chirp-> CHIRP_END (1 cycle)
//   -> WAIT_GATE if chirp_cnt<CHIRP_NUM-1 (chirp_cnt++), else WAIT_CPIE -rise(cpie)-> IDLE.
// - Accept: i_tvalid & i_smp_gate & state==CAPTURE & smp_cnt<SMP_NUM; smp_cnt++ (width log2+1).
//   Samples in IDLE/WAIT_GATE/WAIT_CPIE/CHIRP_END are discarded silently.
// - One-entry staging reg: on accept, previous staged sample (if any) is written to FIFO with
//   tlast=0, new sample staged. End-of-chirp = cycle after smp_cnt reaches SMP_NUM, or fall(gate),
//   whichever first; in CHIRP_END staged sample is written with tlast=1, staging cleared, smp_cnt=0.
//   At most one FIFO write per cycle. Input-to-FIFO latency: next accept, or 1 cycle for last.
// - fall(gate) with smp_cnt==0: no write, no error, chirp still counted. 0<smp_cnt<SMP_NUM: short
//   chirp written (tlast on its last sample) and o_err_short pulses in CHIRP_END.
// - Accept condition fails only because smp_cnt==SMP_NUM while gate high: o_err_long once.
// - tuser=1 on first FIFO write after rise(cpib); chirp_idx = chirp_cnt at staging time.
// - rise(cpib) in any state other than IDLE: o_err_sync, staging discarded, chirp_cnt=0,
//   smp_cnt=0, pri_cnt=0, go WAIT_GATE; FIFO contents kept. rise(cpib) also clears pri_cnt in IDLE.
// - rise(cpie) outside WAIT_CPIE: o_err_sync, no state change. Simultaneous cpib & cpie rise:
//   cpib handled, cpie ignored (no error).
// - FIFO: first-word-fall-through; transfer on o_tvalid & i_tready; write when full drops beat
//   and pulses o_err_ovf (even if same-cycle read would free a slot - read does not help write).
//   Simultaneous read/write when not full: count unchanged. o_tvalid = ~empty.
// - Reset asserted mid-frame: everything (incl. FIFO) clears asynchronously; no partial output.
// TESTING
// 1 Nominal: 1 CPI, tvalid every 8 clk, gate over 4096 beats x32 PRIs, cpie after last -> 131072
//   beats, 32 tlast, 1 tuser on beat 0, chirp_idx 0..31, one o_frame_done, zero errors, data match.
// 2 Backpressure: i_tready 25% duty random, tvalid every 8 clk -> no o_err_ovf, data order intact;
//   i_tready=0 for 20 beats -> exactly 4 o_err_ovf pulses (depth 16), dropped beats absent.
// 3 Short gate: chirp 3 gate closes after 100 beats -> 100 beats, tlast on 100th, 1 o_err_short,
//   chirp 4 indexed 4.
// 4 Long gate: gate open for 4100 beats -> 4096 beats output, 1 o_err_long, next chirp normal.
// 5 Resync: cpib rise during chirp 10 -> 1 o_err_sync, next output beat has tuser=1, chirp_idx=0.
// 6 Reset mid-chirp: rst_n low 3 clk during chirp 5 -> outputs 0, FIFO empty; next CPI nominal.

Source files
------------

// File: rtl/dsp_adc_frame_rx_if.sv
// Output sample stream of the ADC frame receiver toward the range-FFT.
// The stream carries data, end-of-chirp, start-of-frame and the chirp index.
`timescale 1ns/1ps
interface dsp_adc_frame_rx_if #(
    parameter int DW = 16,
    parameter int CW = 5
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tuser;
    logic [CW-1:0] chirp_idx;

    modport master (output tvalid, tdata, tlast, tuser, chirp_idx, input tready);
    modport slave  (input tvalid, tdata, tlast, tuser, chirp_idx, output tready);
endinterface

// File: rtl/dsp_adc_frame_rx.sv
// Radar ADC receive framer: frames gated ADC samples into chirps and CPI frames,
// buffers them in a small first-word-fall-through FIFO and flags timing errors.
`timescale 1ns/1ps
module dsp_adc_frame_rx #(
    parameter int DW         = 16,
    parameter int SMP_NUM    = 4096,
    parameter int CHIRP_NUM  = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cpib,
    input  logic                 i_cpie,
    input  logic                 i_pri,
    input  logic                 i_smp_gate,
    input  logic                 i_tvalid,
    input  logic [DW-1:0]        i_tdata,
    dsp_adc_frame_rx_if.master   m_axis,
    output logic                 o_frame_done,
    output logic                 o_err_short,
    output logic                 o_err_long,
    output logic                 o_err_sync,
    output logic                 o_err_ovf,
    output logic [15:0]          o_pri_cnt
);
    localparam int CW  = (CHIRP_NUM > 1) ? $clog2(CHIRP_NUM) : 1;
    localparam int SCW = $clog2(SMP_NUM) + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int EW  = DW + CW + 2;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_GATE = 3'd1;
    localparam logic [2:0] ST_CAPTURE   = 3'd2;
    localparam logic [2:0] ST_CHIRP_END = 3'd3;
    localparam logic [2:0] ST_WAIT_CPIE = 3'd4;

    logic [2:0]     state_q, state_d;
    logic           cpib_d1_q, cpie_d1_q, pri_d1_q, gate_d1_q;
    logic [SCW-1:0] smp_cnt_q, smp_cnt_d;
    logic [CW-1:0]  chirp_cnt_q, chirp_cnt_d;
    logic [15:0]    pri_cnt_q, pri_cnt_d;
    logic           stg_vld_q, stg_vld_d;
    logic [DW-1:0]  stg_data_q, stg_data_d;
    logic [CW-1:0]  stg_idx_q, stg_idx_d;
    logic           first_q, first_d;       // next FIFO write opens a frame
    logic           over_q, over_d;         // chirp already full, gate still open
    logic           long_seen_q, long_seen_d;
    logic           done_q, done_d, short_q, short_d, long_q, long_d;
    logic           sync_q, sync_d, ovf_q;

    logic [EW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;

    logic rise_cpib, rise_cpie, rise_pri, fall_gate, accept;
    logic wr_en, wr_last, full, push, pop;
    logic [EW-1:0] wr_entry, rd_entry;

    assign rise_cpib = i_cpib & ~cpib_d1_q;
    assign rise_cpie = i_cpie & ~cpie_d1_q;
    assign rise_pri  = i_pri & ~pri_d1_q;
    assign fall_gate = ~i_smp_gate & gate_d1_q;
    // A CPI restart on the same cycle wins over capturing a sample.
    assign accept    = i_tvalid & i_smp_gate & (state_q == ST_CAPTURE) &
                       (smp_cnt_q < SCW'(SMP_NUM)) & ~rise_cpib;

    // Framing FSM, staging register and error detection.
    always_comb begin
        state_d     = state_q;
        smp_cnt_d   = smp_cnt_q;
        chirp_cnt_d = chirp_cnt_q;
        pri_cnt_d   = pri_cnt_q;
        stg_vld_d   = stg_vld_q;
        stg_data_d  = stg_data_q;
        stg_idx_d   = stg_idx_q;
        first_d     = first_q;
        over_d      = over_q;
        long_seen_d = long_seen_q;
        done_d      = 1'b0;
        short_d     = 1'b0;
        long_d      = 1'b0;
        sync_d      = 1'b0;
        wr_en       = 1'b0;
        wr_last     = 1'b0;

        if (rise_cpib) begin
            pri_cnt_d = 16'd0;
        end else if (rise_pri) begin
            pri_cnt_d = pri_cnt_q + 16'd1;
        end

        // A full chirp must not re-arm on the same gate; extra samples flag once.
        if (~i_smp_gate) begin
            over_d      = 1'b0;
            long_seen_d = 1'b0;
        end
        if (accept && smp_cnt_q == SCW'(SMP_NUM - 1)) begin
            over_d = 1'b1;
        end
        if (i_tvalid && i_smp_gate && over_q && !long_seen_q) begin
            long_d      = 1'b1;
            long_seen_d = 1'b1;
        end

        if (rise_cpib) begin
            sync_d      = (state_q != ST_IDLE);
            first_d     = 1'b1;
            chirp_cnt_d = '0;
            smp_cnt_d   = '0;
            stg_vld_d   = 1'b0;
            state_d     = ST_WAIT_GATE;
        end else begin
            if (rise_cpie && state_q != ST_WAIT_CPIE) begin
                sync_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: ;
                ST_WAIT_GATE: begin
                    if (i_smp_gate && !over_q) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (accept) begin
                        wr_en      = stg_vld_q;
                        stg_vld_d  = 1'b1;
                        stg_data_d = i_tdata;
                        stg_idx_d  = chirp_cnt_q;
                        smp_cnt_d  = smp_cnt_q + 1'b1;
                    end else if (smp_cnt_q == SCW'(SMP_NUM) || fall_gate) begin
                        state_d = ST_CHIRP_END;
                    end
                end
                ST_CHIRP_END: begin
                    wr_en     = stg_vld_q;
                    wr_last   = 1'b1;
                    stg_vld_d = 1'b0;
                    smp_cnt_d = '0;
                    short_d   = (smp_cnt_q != '0) && (smp_cnt_q < SCW'(SMP_NUM));
                    if (chirp_cnt_q < CW'(CHIRP_NUM - 1)) begin
                        chirp_cnt_d = chirp_cnt_q + 1'b1;
                        state_d     = ST_WAIT_GATE;
                    end else begin
                        state_d = ST_WAIT_CPIE;
                    end
                end
                ST_WAIT_CPIE: begin
                    if (rise_cpie) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (wr_en) first_d = 1'b0;
        end
    end

    assign wr_entry = {first_q, wr_last, stg_idx_q, stg_data_q};
    assign full     = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign push     = wr_en & ~full;
    assign pop      = (count_q != '0) & m_axis.tready;

    // Control state, counters and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cpib_d1_q   <= 1'b0;
            cpie_d1_q   <= 1'b0;
            pri_d1_q    <= 1'b0;
            gate_d1_q   <= 1'b0;
            smp_cnt_q   <= '0;
            chirp_cnt_q <= '0;
            pri_cnt_q   <= '0;
            stg_vld_q   <= 1'b0;
            stg_data_q  <= '0;
            stg_idx_q   <= '0;
            first_q     <= 1'b0;
            over_q      <= 1'b0;
            long_seen_q <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            sync_q      <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cpib_d1_q   <= i_cpib;
            cpie_d1_q   <= i_cpie;
            pri_d1_q    <= i_pri;
            gate_d1_q   <= i_smp_gate;
            smp_cnt_q   <= smp_cnt_d;
            chirp_cnt_q <= chirp_cnt_d;
            pri_cnt_q   <= pri_cnt_d;
            stg_vld_q   <= stg_vld_d;
            stg_data_q  <= stg_data_d;
            stg_idx_q   <= stg_idx_d;
            first_q     <= first_d;
            over_q      <= over_d;
            long_seen_q <= long_seen_d;
            done_q      <= done_d;
            short_q     <= short_d;
            long_q      <= long_d;
            sync_q      <= sync_d;
            ovf_q       <= wr_en & full;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; the head is read combinationally so the output falls through.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign rd_entry         = mem_q[rd_ptr_q];
    assign m_axis.tvalid    = (count_q != '0);
    assign m_axis.tdata     = rd_entry[DW-1:0];
    assign m_axis.chirp_idx = rd_entry[DW+CW-1:DW];
    assign m_axis.tlast     = rd_entry[DW+CW];
    assign m_axis.tuser     = rd_entry[DW+CW+1];

    assign o_frame_done = done_q;
    assign o_err_short  = short_q;
    assign o_err_long   = long_q;
    assign o_err_sync   = sync_q;
    assign o_err_ovf    = ovf_q;
    assign o_pri_cnt    = pri_cnt_q;
endmodule

// File: tb/tb_dsp_adc_frame_rx.sv
// Randomized bench for dsp_adc_frame_rx with a chirp-level reference model.
`timescale 1ns/1ps
module tb_dsp_adc_frame_rx;
    localparam int DW  = 16;
    localparam int SMP = 20;
    localparam int CHN = 4;
    localparam int FD  = 16;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_cpib, i_cpie, i_pri, i_smp_gate, i_tvalid;
    logic [DW-1:0] i_tdata;
    logic          o_frame_done, o_err_short, o_err_long, o_err_sync, o_err_ovf;
    logic [15:0]   o_pri_cnt;

    dsp_adc_frame_rx_if #(.DW(DW), .CW(CW)) m_axis ();

    dsp_adc_frame_rx #(.DW(DW), .SMP_NUM(SMP), .CHIRP_NUM(CHN), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .i_cpib(i_cpib), .i_cpie(i_cpie), .i_pri(i_pri),
        .i_smp_gate(i_smp_gate), .i_tvalid(i_tvalid), .i_tdata(i_tdata), .m_axis(m_axis),
        .o_frame_done(o_frame_done), .o_err_short(o_err_short), .o_err_long(o_err_long),
        .o_err_sync(o_err_sync), .o_err_ovf(o_err_ovf), .o_pri_cnt(o_pri_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        logic [CW-1:0] idx;
    } beat_t;

    beat_t exp_q[$];
    beat_t e;
    int n_chk = 0, n_fail = 0;
    int cnt_short = 0, cnt_long = 0, cnt_sync = 0, cnt_ovf = 0, cnt_done = 0;
    int exp_short = 0, exp_long = 0, exp_sync = 0, exp_ovf = 0, exp_done = 0;
    int m_chirp = 0, m_pri = 0;
    bit m_first = 1'b0;
    int tready_mode = 0;   // 0: always ready, 1: random 25 %, 2: stalled

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Downstream ready generator.
    always @(posedge clk) begin
        #1;
        case (tready_mode)
            0:       m_axis.tready = 1'b1;
            1:       m_axis.tready = ($urandom_range(3) == 0);
            default: m_axis.tready = 1'b0;
        endcase
    end

    // Output monitor: scoreboard compare per transferred beat, pulse counting.
    always @(negedge clk) begin
        if (rst_n) begin
            cnt_short += int'(o_err_short);
            cnt_long  += int'(o_err_long);
            cnt_sync  += int'(o_err_sync);
            cnt_ovf   += int'(o_err_ovf);
            cnt_done  += int'(o_frame_done);
            if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
                check_eq("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("tdata", 32'(m_axis.tdata), 32'(e.data));
                    check_eq("tlast", 32'(m_axis.tlast), 32'(e.last));
                    check_eq("tuser", 32'(m_axis.tuser), 32'(e.user));
                    check_eq("chirp_idx", 32'(m_axis.chirp_idx), 32'(e.idx));
                    $display("beat data=%h last=%0d user=%0d idx=%0d", m_axis.tdata,
                             m_axis.tlast, m_axis.tuser, m_axis.chirp_idx);
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One ADC sample followed by 7 idle clocks; optionally expected at the output.
    task automatic drive_sample(input bit expect_out, input bit last);
        beat_t b;
        logic [DW-1:0] d;
        d = DW'($urandom);
        i_tdata  = d;
        i_tvalid = 1'b1;
        if (expect_out) begin
            b.data = d;
            b.last = last;
            b.user = m_first;
            b.idx  = m_chirp[CW-1:0];
            exp_q.push_back(b);
            m_first = 1'b0;
        end
        cyc();
        i_tvalid = 1'b0;
        cyc(7);
    endtask

    task automatic frame_start(input bit with_cpie);
        i_cpib = 1'b1;
        i_cpie = with_cpie;
        cyc();
        i_cpib = 1'b0;
        i_cpie = 1'b0;
        cyc();
        m_chirp = 0;
        m_first = 1'b1;
        m_pri   = 0;
    endtask

    task automatic frame_end();
        i_cpie = 1'b1;
        cyc();
        i_cpie = 1'b0;
        cyc(2);
        exp_done++;
    endtask

    // A gate window carrying n samples; at most keep beats survive the FIFO.
    task automatic gate(input int n, input int keep);
        int len;
        len = (n < SMP) ? n : SMP;
        i_pri      = 1'b1;
        i_smp_gate = 1'b1;
        cyc();
        i_pri = 1'b0;
        cyc();
        m_pri++;
        for (int k = 0; k < n; k++) drive_sample(k < len && k < keep, k == len - 1);
        if (len > keep) exp_ovf += len - keep;
        if (len > 0 && len < SMP) exp_short++;
        if (n > SMP) exp_long++;
        i_smp_gate = 1'b0;
        cyc(4);
        m_chirp++;
    endtask

    task automatic drain_and_check(input string tag);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) cyc();
        cyc(4);
        check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_fifo_empty"}, 32'(m_axis.tvalid), 32'd0);
        check_eq({tag, "_err_short"}, 32'(cnt_short), 32'(exp_short));
        check_eq({tag, "_err_long"}, 32'(cnt_long), 32'(exp_long));
        check_eq({tag, "_err_sync"}, 32'(cnt_sync), 32'(exp_sync));
        check_eq({tag, "_err_ovf"}, 32'(cnt_ovf), 32'(exp_ovf));
        check_eq({tag, "_frame_done"}, 32'(cnt_done), 32'(exp_done));
        check_eq({tag, "_pri_cnt"}, 32'(o_pri_cnt), 32'(m_pri));
        $display("test %s complete", tag);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_tvalid"}, 32'(m_axis.tvalid), 32'd0);
        check_eq({tag, "_pri_cnt"}, 32'(o_pri_cnt), 32'd0);
        check_eq({tag, "_pulses"}, 32'({o_frame_done, o_err_short, o_err_long,
                                        o_err_sync, o_err_ovf}), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        {i_cpib, i_cpie, i_pri, i_smp_gate, i_tvalid} = '0;
        i_tdata = '0;
        cyc(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        cyc(3);

        // Nominal frame, cpie rising together with cpib is ignored.
        frame_start(1'b1);
        for (int c = 0; c < CHN; c++) gate(SMP, SMP);
        frame_end();
        drain_and_check("nominal");

        // Random backpressure.
        tready_mode = 1;
        frame_start(1'b0);
        for (int c = 0; c < CHN; c++) gate(SMP, SMP);
        frame_end();
        drain_and_check("backpressure");

        // Stalled output through a whole chirp: FIFO keeps FD beats.
        tready_mode = 2;
        cyc(2);
        frame_start(1'b0);
        gate(SMP, FD);
        tready_mode = 0;
        for (int c = 1; c < CHN; c++) gate(SMP, SMP);
        frame_end();
        drain_and_check("overflow");

        // Short gate, empty gate, and a random-length short gate.
        frame_start(1'b0);
        gate(SMP, SMP);
        gate(7, SMP);
        gate(0, SMP);
        gate(int'($urandom_range(SMP - 1, 1)), SMP);
        frame_end();
        drain_and_check("short");

        // Overlong gate, plus a stray cpie rise mid-frame.
        frame_start(1'b0);
        gate(SMP, SMP);
        i_cpie = 1'b1;
        cyc();
        i_cpie = 1'b0;
        cyc();
        exp_sync++;
        gate(SMP + 3, SMP);
        gate(SMP, SMP);
        gate(SMP, SMP);
        frame_end();
        drain_and_check("long");

        // cpib rise in the middle of chirp 2: last staged sample is discarded.
        frame_start(1'b0);
        gate(SMP, SMP);
        gate(SMP, SMP);
        i_pri      = 1'b1;
        i_smp_gate = 1'b1;
        cyc();
        i_pri = 1'b0;
        cyc();
        m_pri++;
        for (int k = 0; k < 5; k++) drive_sample(k < 4, 1'b0);
        i_cpib = 1'b1;
        cyc();
        i_cpib = 1'b0;
        cyc(2);
        exp_sync++;
        m_chirp = 0;
        m_first = 1'b1;
        m_pri   = 0;
        for (int k = 0; k < 9; k++) drive_sample(1'b1, k == 8);
        exp_short++;
        i_smp_gate = 1'b0;
        cyc(4);
        m_chirp = 1;
        for (int c = 1; c < CHN; c++) gate(SMP, SMP);
        frame_end();
        drain_and_check("resync");

        // Reset in the middle of a chirp, then a nominal frame.
        frame_start(1'b0);
        gate(SMP, SMP);
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) cyc();
        i_smp_gate = 1'b1;
        cyc(2);
        for (int k = 0; k < 10; k++) drive_sample(k < 9, 1'b0);
        check_eq("pre_reset_queue", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        i_smp_gate = 1'b0;
        #2;
        check_idle_outputs("async_reset");
        cyc(3);
        check_idle_outputs("mid_reset");
        rst_n = 1'b1;
        exp_q.delete();
        m_pri = 0;
        cyc(3);
        frame_start(1'b0);
        for (int c = 0; c < CHN; c++) gate(SMP, SMP);
        frame_end();
        drain_and_check("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
